// File: rtl/ram_rd_pkg.sv
// Shared types and default sizes for the RAM stream reader.
// The optional Abort input is built in when RAM_RD_ABORT_EN is defined.
package ram_rd_pkg;

  localparam int RD_ADDR_W_DEF = 10;
  localparam int RD_DATA_W_DEF = 16;
  localparam int RD_LAT_DEF    = 2;
  localparam int RD_FIFO_D_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream of the RAM stream reader.
// Carries the Abort input only when RAM_RD_ABORT_EN is defined.
interface ram_stream_reader_if
  import ram_rd_pkg::*;
#(
  parameter int ADDR_W = RD_ADDR_W_DEF,
  parameter int DATA_W = RD_DATA_W_DEF
);

  logic              Start;
  logic [ADDR_W-1:0] StartAddr;
  logic [ADDR_W:0]   Len;
  logic              Busy;
  logic              Done;
  logic [ADDR_W-1:0] RA;
  logic              RClk_En;
  logic [DATA_W-1:0] RD;
  logic [DATA_W-1:0] DOut;
  logic              DOut_Valid;
  logic              DOut_Ready;
`ifdef RAM_RD_ABORT_EN
  logic              Abort;
`endif

  // The reader is the master; the command source, RAM and consumer are the slave side.
  modport master (
`ifdef RAM_RD_ABORT_EN
    input  Abort,
`endif
    input  Start, StartAddr, Len, RD, DOut_Ready,
    output Busy, Done, RA, RClk_En, DOut, DOut_Valid
  );

  modport slave (
`ifdef RAM_RD_ABORT_EN
    output Abort,
`endif
    output Start, StartAddr, Len, RD, DOut_Ready,
    input  Busy, Done, RA, RClk_En, DOut, DOut_Valid
  );

endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Small synchronous FIFO buffering RAM return words ahead of the output stream.
// Flush empties it in one cycle; the head is driven to zero while empty.
module ram_rd_skid_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && (r_count != '0) && !i_flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: the storage array is deliberately not reset; validity is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

  // The reader's credit scheme must never push into a full buffer without a matching pop.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read initiator: drives RA/RClk_En, absorbs RAM latency, emits a valid/ready stream.
// Defining RAM_RD_ABORT_EN adds an Abort input that ends a burst early.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int ADDR_W = RD_ADDR_W_DEF,
  parameter int DATA_W = RD_DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int FIFO_D = RD_FIFO_D_DEF
) (
  input logic                 Clk,
  input logic                 Rst,
  ram_stream_reader_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int SUM_W = $clog2(FIFO_D + RD_LAT + 1);

  if (RD_LAT < 1 || FIFO_D < RD_LAT + 1) begin : g_bad_cfg
    $error("ram_stream_reader: need RD_LAT >= 1 and FIFO_D >= RD_LAT+1");
  end

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [RD_LAT-1:0] r_pipe;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_fifo_data;
  logic              w_fifo_valid;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_drained;
  logic              w_abort;

`ifdef RAM_RD_ABORT_EN
  assign w_abort = bus.Abort && ((r_state == RUN) || (r_state == DRAIN));
`else
  assign w_abort = 1'b0;
`endif

  // Credit counts buffered words plus reads still in the RAM pipe, so every issued word has a slot.
  assign w_credit_ok  = (SUM_W'(w_fifo_count) + SUM_W'($countones(r_pipe))) < SUM_W'(FIFO_D);
  assign w_issue      = (r_state == RUN) && w_credit_ok && !w_abort;
  assign w_last_issue = w_issue && (r_remaining == (ADDR_W+1)'(1));
  assign w_push       = r_pipe[RD_LAT-1] && !w_abort;
  assign w_pop        = w_fifo_valid && bus.DOut_Ready;
  assign w_drained    = (r_pipe == '0) && (w_fifo_count == CNT_W'(w_pop));

  // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.Start) w_state_nxt = (bus.Len == '0) ? DONE : RUN;
      RUN:     if (w_abort) w_state_nxt = DONE;
               else if (w_last_issue) w_state_nxt = DRAIN;
      DRAIN:   if (w_abort || w_drained) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_pipe      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pipe  <= w_abort ? '0 : ((r_pipe << 1) | RD_LAT'(w_issue));
      if ((r_state == IDLE) && bus.Start) begin
        r_addr      <= bus.StartAddr;
        r_remaining <= bus.Len;
      end else if (w_issue) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  ram_rd_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_data  (bus.RD),
    .i_pop   (w_pop),
    .i_flush (w_abort),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign bus.Busy       = (r_state != IDLE);
  assign bus.Done       = (r_state == DONE);
  assign bus.RA         = r_addr;
  assign bus.RClk_En    = w_issue;
  assign bus.DOut       = w_fifo_data;
  assign bus.DOut_Valid = w_fifo_valid;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: queue-based model of burst contents plus directed edge cases.
module tb_ram_stream_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int FIFO_D = 4;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_stream_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (2),
    .FIFO_D (FIFO_D)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  // Registered-read RAM model: address sampled with RClk_En, data one edge later.
  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] ra_q;
  logic [DATA_W-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.RClk_En) ra_q <= bus.RA;
    rd_q <= ram[ra_q];
  end
  assign bus.RD = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] ra_log [$];
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] last_dout;
  int cur_len, issued, xfers, done_cnt;
  int neg_cyc, first_xfer_cyc, last_xfer_cyc;
  bit mon_en     = 1'b0;
  bit rand_ready = 1'b0;
  int hold0      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, check issue addresses, credit, stream data and Done timing.
  initial forever begin
    @(negedge clk);
    neg_cyc++;
    if (!rst && mon_en) begin
      if (bus.RClk_En) begin
        check("ra_seq", bus.RA, exp_addr);
        ra_log.push_back(bus.RA);
        exp_addr = exp_addr + 1'b1;
        issued++;
        check("issue_bound", (issued <= cur_len), 1);
        check("credit", ((issued - xfers) <= FIFO_D), 1);
      end
      if (bus.DOut_Valid && bus.DOut_Ready) begin
        check("xfer_bound", (xfers < cur_len), 1);
        if (exp_q.size() > 0) check("dout", bus.DOut, exp_q.pop_front());
        if (xfers == 0) first_xfer_cyc = neg_cyc;
        last_xfer_cyc = neg_cyc;
        last_dout = bus.DOut;
        xfers++;
      end
      if (bus.Done) begin
        check("done_q_empty", exp_q.size(), 0);
        if (cur_len != 0) check("done_after_last", neg_cyc - last_xfer_cyc, 1);
        done_cnt++;
      end
    end
  end

  // Consumer: ready forced low while hold0 runs, random when rand_ready, else held high.
  initial forever begin
    @(posedge clk);
    #2;
    if (hold0 > 0) begin
      bus.DOut_Ready = 1'b0;
      hold0--;
    end else if (rand_ready) bus.DOut_Ready = ($urandom_range(0, 1) == 1);
    else bus.DOut_Ready = 1'b1;
  end

  task automatic start_burst(input logic [ADDR_W-1:0] a, input int l);
    exp_q.delete();
    ra_log.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(ram[ADDR_W'(int'(a) + i)]);
    exp_addr = a;
    cur_len  = l;
    issued   = 0;
    xfers    = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
    bus.StartAddr = a;
    bus.Len       = (ADDR_W+1)'(l);
    bus.Start     = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic finish_burst(input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("done_seen", done_cnt, 1);
    @(posedge clk);
    #1;
    check("idle_after_done", bus.Busy, 0);
    @(negedge clk);
    check("done_once", done_cnt, 1);
    check("issued_total", issued, cur_len);
    check("xfer_total", xfers, cur_len);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, bus.Busy, 0);
    check({tag, "_done"}, bus.Done, 0);
    check({tag, "_ra"}, bus.RA, 0);
    check({tag, "_ren"}, bus.RClk_En, 0);
    check({tag, "_dout"}, bus.DOut, 0);
    check({tag, "_valid"}, bus.DOut_Valid, 0);
  endtask

  initial begin
    int lat;
    int len;
    int c;
    bus.Start      = 1'b0;
    bus.StartAddr  = '0;
    bus.Len        = '0;
    bus.DOut_Ready = 1'b1;
`ifdef RAM_RD_ABORT_EN
    bus.Abort      = 1'b0;
`endif
    for (int a = 0; a < DEPTH; a++) ram[a] = DATA_W'(a);

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic burst: words 0x0010..0x0017, first valid three edges after Start.
    start_burst(10'h010, 8);
    lat = 0;
    while (!bus.DOut_Valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("first_valid_lat", lat, 3);
    check("first_word", bus.DOut, 16'h0010);
    finish_burst(200);
    check("basic_throughput", last_xfer_cyc - first_xfer_cyc, 7);
    check("basic_last", last_dout, 16'h0017);

    // Address wrap at the top of the RAM.
    start_burst(10'h3FE, 4);
    finish_burst(200);
    check("wrap_ra_cnt", ra_log.size(), 4);
    if (ra_log.size() == 4) begin
      check("wrap_ra0", ra_log[0], 10'h3FE);
      check("wrap_ra1", ra_log[1], 10'h3FF);
      check("wrap_ra2", ra_log[2], 10'h000);
      check("wrap_ra3", ra_log[3], 10'h001);
    end
    check("wrap_last", last_dout, 16'h0001);

    // Zero-length command: Done the very next cycle, no reads.
    start_burst(10'h123, 0);
    check("len0_done", bus.Done, 1);
    check("len0_ren", bus.RClk_En, 0);
    @(posedge clk);
    #1;
    check("len0_done_clear", bus.Done, 0);
    check("len0_idle", bus.Busy, 0);
    @(negedge clk);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_issued", issued, 0);

    // Start while busy must be ignored.
    start_burst(10'h100, 12);
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid", bus.Busy, 1);
    bus.StartAddr = 10'h200;
    bus.Len       = 11'd5;
    bus.Start     = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    finish_burst(300);

    // Back-pressure: with ready held low, issuing stops once the buffer credit is used.
    hold0 = 25;
    start_burst(10'h040, 16);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_issued", issued, FIFO_D);
    check("bp_xfers", xfers, 0);
    rand_ready = 1'b1;
    finish_burst(600);

    // Randomised bursts over random RAM contents.
    for (int a = 0; a < DEPTH; a++) ram[a] = DATA_W'($urandom);
    for (int n = 0; n < 12; n++) begin
      len = (n == 5) ? 0 : int'($urandom_range(1, 48));
      if (n % 4 == 3) hold0 = int'($urandom_range(5, 20));
      start_burst(ADDR_W'($urandom), len);
      finish_burst(8 * len + 200);
    end

    // Full sweep at full throughput.
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_burst(10'h155, 1024);
    finish_burst(1400);
    check("sweep_throughput", last_xfer_cyc - first_xfer_cyc, 1023);

    // Reset mid-burst: outputs return to zero immediately and stay idle.
    start_burst(10'h050, 40);
    repeat (10) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_ren", bus.RClk_En, 0);
      check("post_rst_valid", bus.DOut_Valid, 0);
      check("post_rst_busy", bus.Busy, 0);
    end
    start_burst(10'h2F0, 10);
    finish_burst(200);

`ifdef RAM_RD_ABORT_EN
    // Abort after five words: stream empties next cycle, Done pulses once, next burst works.
    start_burst(10'h080, 16);
    c = 0;
    while (xfers < 5 && c < 100) begin
      @(posedge clk);
      c++;
    end
    check("abort_reach5", (xfers >= 5), 1);
    #1;
    mon_en    = 1'b0;
    bus.Abort = 1'b1;
    @(posedge clk);
    #1;
    bus.Abort = 1'b0;
    check("abort_valid", bus.DOut_Valid, 0);
    check("abort_done", bus.Done, 1);
    check("abort_ren", bus.RClk_En, 0);
    @(posedge clk);
    #1;
    check("abort_done_once", bus.Done, 0);
    check("abort_idle", bus.Busy, 0);
    start_burst(10'h0A0, 6);
    finish_burst(200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
